parking_request_queue: RTL and testbench

- Front-end stage directly upstream of the parking-lot core FSM.
- Samples raw entry/exit requests (in_mode/out_mode pulses with a BCD license plate) and validates them.
- Buffers valid requests in a FIFO while the elevator is busy.
- Issues each request to the core as a one-cycle in_mode_internal/out_mode_internal pulse with license_plate_internal, only when the core reports idle.

---
 rtl/parking_request_queue.sv | 129 ++++++++++++
 tb/tb_parking_request_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/parking_request_queue.sv
// Validating request FIFO in front of the parking-lot core FSM; issues one-cycle commands when idle.
// Optional duplicate-request filter enabled by defining REQ_DUP_FILTER_EN.
module parking_request_queue #(
  parameter int unsigned PTR_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [15:0]      license_plate,
  input  logic             in_mode,
  input  logic             out_mode,
  input  logic             core_ready,
  input  logic             hold,
  output logic             in_mode_internal,
  output logic             out_mode_internal,
  output logic [15:0]      license_plate_internal,
  output logic [PTR_W:0]   queue_count,
  output logic             overflow,
  output logic             bad_request,
  output logic [7:0]       drop_count
);

  localparam int unsigned DEPTH = 2 ** PTR_W;
  localparam int unsigned ENT_W = 17;
  localparam logic [PTR_W:0] CountFull = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] CountOne = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PtrOne = PTR_W'(1);

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_in_int;
  logic             r_out_int;
  logic [15:0]      r_plate;
  logic             r_overflow;
  logic             r_bad;
  logic [7:0]       r_drop;

  logic             w_any;
  logic             w_both;
  logic             w_digits_ok;
  logic             w_bad;
  logic             w_dup;
  logic             w_valid;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_overflow;
  logic [ENT_W-1:0] w_entry;
  logic [ENT_W-1:0] w_head;

  always_comb begin
    w_digits_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (license_plate[4*i +: 4] > 4'd9) w_digits_ok = 1'b0;
    end
  end

  assign w_any   = in_mode | out_mode;
  assign w_both  = in_mode & out_mode;
  assign w_bad   = w_any & (w_both | ~w_digits_ok | ~(|license_plate));
  assign w_entry = {in_mode, license_plate};

`ifdef REQ_DUP_FILTER_EN
  logic [PTR_W-1:0] w_off;

  // A slot is occupied when its distance from the read pointer is below the count;
  // this uses pre-edge state, so a head popping on this edge still matches.
  always_comb begin
    w_dup = 1'b0;
    w_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PTR_W'(i) - r_rd_ptr;
      if (({1'b0, w_off} < r_count) && (r_mem[i] == w_entry)) w_dup = 1'b1;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  assign w_valid    = w_any & ~w_bad & ~w_dup;
  assign w_full     = (r_count == CountFull);
  assign w_pop      = (r_count != '0) & core_ready & ~hold & ~r_in_int & ~r_out_int;
  assign w_push     = w_valid & (~w_full | w_pop);
  assign w_overflow = w_valid & ~w_push;
  assign w_head     = r_mem[r_rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_int   <= 1'b0;
      r_out_int  <= 1'b0;
      r_plate    <= '0;
      r_overflow <= 1'b0;
      r_bad      <= 1'b0;
      r_drop     <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrOne;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrOne;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CountOne;
        2'b01:   r_count <= r_count - CountOne;
        default: r_count <= r_count;
      endcase
      r_in_int  <= w_pop & w_head[16];
      r_out_int <= w_pop & ~w_head[16];
      if (w_pop) r_plate <= w_head[15:0];
      r_overflow <= w_overflow;
      r_bad      <= w_bad;
      if ((w_overflow | w_bad) && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

  // Storage needs no reset: occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  assign in_mode_internal       = r_in_int;
  assign out_mode_internal      = r_out_int;
  assign license_plate_internal = r_plate;
  assign queue_count            = r_count;
  assign overflow               = r_overflow;
  assign bad_request            = r_bad;
  assign drop_count             = r_drop;

endmodule

// File: tb/tb_parking_request_queue.sv
// Directed scoreboard bench for parking_request_queue; define REQ_DUP_FILTER_EN to match the RTL build.
module tb_parking_request_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] license_plate;
  logic        in_mode;
  logic        out_mode;
  logic        core_ready;
  logic        hold;
  logic        in_mode_internal;
  logic        out_mode_internal;
  logic [15:0] license_plate_internal;
  logic [2:0]  queue_count;
  logic        overflow;
  logic        bad_request;
  logic [7:0]  drop_count;

  parking_request_queue #(.PTR_W(2)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .license_plate          (license_plate),
    .in_mode                (in_mode),
    .out_mode               (out_mode),
    .core_ready             (core_ready),
    .hold                   (hold),
    .in_mode_internal       (in_mode_internal),
    .out_mode_internal      (out_mode_internal),
    .license_plate_internal (license_plate_internal),
    .queue_count            (queue_count),
    .overflow               (overflow),
    .bad_request            (bad_request),
    .drop_count             (drop_count)
  );

  always #5 clock = ~clock;

  logic [16:0] sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pulses = 0;
  logic        prev_pulse = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, and score any issue pulse.
  task automatic tick();
    logic [16:0] exp;
    logic        pulse;
    @(posedge clock);
    #1;
    pulse = in_mode_internal | out_mode_internal;
    if (pulse) begin
      n_pulses++;
      chk("issue_gap", {31'd0, prev_pulse}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_issue", {30'd0, in_mode_internal, out_mode_internal}, 32'd0);
      end else begin
        exp = sb.pop_front();
        chk("issue_entry", {13'd0, in_mode_internal, out_mode_internal, license_plate_internal},
            {13'd0, exp[16], ~exp[16], exp[15:0]});
      end
    end
    prev_pulse = pulse;
  endtask

  task automatic send(input logic im, input logic om, input logic [15:0] p, input bit acc);
    in_mode       = im;
    out_mode      = om;
    license_plate = p;
    if (acc) sb.push_back({im, p});
    tick();
    in_mode  = 1'b0;
    out_mode = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 40;
    while ((sb.size() != 0 || in_mode_internal || out_mode_internal) && budget > 0) begin
      tick();
      budget--;
    end
    chk({tag, "_drained"}, sb.size(), 32'd0);
    chk({tag, "_count0"}, {29'd0, queue_count}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    reset         = 1'b1;
    in_mode       = 1'b0;
    out_mode      = 1'b0;
    license_plate = '0;
    core_ready    = 1'b1;
    hold          = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_count", {29'd0, queue_count}, 32'd0);
    chk("rst_drop", {24'd0, drop_count}, 32'd0);
    chk("rst_pulses", {29'd0, in_mode_internal, out_mode_internal, overflow}, 32'd0);
    chk("rst_bad", {31'd0, bad_request}, 32'd0);
    chk("rst_plate", {16'd0, license_plate_internal}, 32'd0);

    // 1: single request latency
    send(1'b1, 1'b0, 16'h9423, 1'b1);
    chk("t1_count_n", {29'd0, queue_count}, 32'd1);
    chk("t1_no_issue_n", {31'd0, in_mode_internal}, 32'd0);
    tick();
    chk("t1_in_int", {31'd0, in_mode_internal}, 32'd1);
    chk("t1_plate", {16'd0, license_plate_internal}, 32'h9423);
    tick();
    chk("t1_in_int_low", {31'd0, in_mode_internal}, 32'd0);
    chk("t1_count_n2", {29'd0, queue_count}, 32'd0);

    // 2: fill, overflow, ordered drain
    core_ready = 1'b0;
    send(1'b1, 1'b0, 16'h9423, 1'b1);
    send(1'b1, 1'b0, 16'h8754, 1'b1);
    send(1'b0, 1'b1, 16'h8754, 1'b1);
    send(1'b1, 1'b0, 16'h1111, 1'b1);
    chk("t2_count4", {29'd0, queue_count}, 32'd4);
    send(1'b1, 1'b0, 16'h2222, 1'b0);
    chk("t2_overflow", {31'd0, overflow}, 32'd1);
    chk("t2_drop1", {24'd0, drop_count}, 32'd1);
    chk("t2_count_still4", {29'd0, queue_count}, 32'd4);
    tick();
    chk("t2_overflow_pulse", {31'd0, overflow}, 32'd0);
    p0 = n_pulses;
    core_ready = 1'b1;
    drain("t2");
    chk("t2_pulses", n_pulses - p0, 32'd4);

    // 3: validation rejects
    send(1'b1, 1'b1, 16'h1234, 1'b0);
    chk("t3_bad_both", {31'd0, bad_request}, 32'd1);
    chk("t3_drop2", {24'd0, drop_count}, 32'd2);
    send(1'b1, 1'b0, 16'h12A4, 1'b0);
    chk("t3_bad_nibble", {31'd0, bad_request}, 32'd1);
    chk("t3_drop3", {24'd0, drop_count}, 32'd3);
    send(1'b1, 1'b0, 16'h0000, 1'b0);
    chk("t3_bad_zero", {31'd0, bad_request}, 32'd1);
    chk("t3_drop4", {24'd0, drop_count}, 32'd4);
    chk("t3_count0", {29'd0, queue_count}, 32'd0);
    tick();
    chk("t3_bad_pulse", {31'd0, bad_request}, 32'd0);

    // 4: hold suppresses issue
    hold = 1'b1;
    p0   = n_pulses;
    send(1'b1, 1'b0, 16'h3333, 1'b1);
    send(1'b0, 1'b1, 16'h4444, 1'b1);
    repeat (4) tick();
    chk("t4_no_pulse", n_pulses - p0, 32'd0);
    chk("t4_count2", {29'd0, queue_count}, 32'd2);
    hold = 1'b0;
    tick();
    chk("t4_first_after_hold", {31'd0, in_mode_internal}, 32'd1);
    drain("t4");

    // 5: push and pop on the same edge while full
    core_ready = 1'b0;
    send(1'b1, 1'b0, 16'h1001, 1'b1);
    send(1'b1, 1'b0, 16'h1002, 1'b1);
    send(1'b1, 1'b0, 16'h1003, 1'b1);
    send(1'b1, 1'b0, 16'h1004, 1'b1);
    chk("t5_full", {29'd0, queue_count}, 32'd4);
    core_ready = 1'b1;
    send(1'b1, 1'b0, 16'h1005, 1'b1);
    chk("t5_count4", {29'd0, queue_count}, 32'd4);
    chk("t5_no_overflow", {31'd0, overflow}, 32'd0);
    chk("t5_drop_same", {24'd0, drop_count}, 32'd4);
    drain("t5");

    // 6: reset mid-pulse
    core_ready = 1'b0;
    send(1'b0, 1'b1, 16'h5555, 1'b1);
    core_ready = 1'b1;
    tick();
    chk("t6_out_int", {31'd0, out_mode_internal}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_pulse", {30'd0, in_mode_internal, out_mode_internal}, 32'd0);
    chk("t6_rst_count", {29'd0, queue_count}, 32'd0);
    chk("t6_rst_drop", {24'd0, drop_count}, 32'd0);
    chk("t6_rst_plate", {16'd0, license_plate_internal}, 32'd0);
    core_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    send(1'b1, 1'b0, 16'h9423, 1'b1);
`ifdef REQ_DUP_FILTER_EN
    send(1'b1, 1'b0, 16'h9423, 1'b0);
    chk("t6_dup_count", {29'd0, queue_count}, 32'd1);
`else
    send(1'b1, 1'b0, 16'h9423, 1'b1);
    chk("t6_dup_count", {29'd0, queue_count}, 32'd2);
`endif
    chk("t6_dup_drop", {24'd0, drop_count}, 32'd0);
    chk("t6_dup_flags", {30'd0, overflow, bad_request}, 32'd0);
    core_ready = 1'b1;
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
